// File: rtl/pc_fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack port and decode valid/ready port.
// master = fetch stage, slave = memory/decode side.
interface pc_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4,
    input  imem_ack, imem_rdata, if_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4,
    output imem_ack, imem_rdata, if_ready
  );
endinterface

// File: rtl/pc_fetch_stage.sv
// Instruction-fetch front end: PC register, req/ack fetch FSM with redirect
// handling, and a 2-entry fetch queue feeding decode over valid/ready.
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] PC_INC    = 32'd4,
  parameter int          BUF_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic [31:0]      add_in1,
  output logic [31:0]      add_in2,
  input  logic [31:0]      add_sum,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  pc_fetch_stage_if.master fetch
);

  typedef enum logic [1:0] {IDLE, FETCH, DROP} state_t;

  localparam logic [1:0] FULL_COUNT = 2'(BUF_DEPTH);

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] addr_reg;
  logic        req_reg;
  logic [1:0]  count_reg;
  logic [1:0]  count_next;
  logic        rd_ptr_reg;
  logic        wr_ptr_reg;
  logic [31:0] q_instr_reg [BUF_DEPTH];
  logic [31:0] q_pc_reg    [BUF_DEPTH];
  logic [31:0] q_pc4_reg   [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] wr_en;
  logic        push;
  logic        pop;
  logic        below_full;
  logic [31:0] target_pc;

  assign target_pc = {redirect_pc[31:2], 2'b00};
  assign add_in1   = pc_reg;
  assign add_in2   = PC_INC;

  // A redirect squashes the accepted word, so it never enters the queue.
  assign push = (state_reg == FETCH) && fetch.imem_ack && !redirect_valid;
  assign pop  = (count_reg != 2'd0) && fetch.if_ready;

  always_comb begin
    count_next = count_reg;
    if (redirect_valid)
      count_next = 2'd0;
    else
      count_next = count_reg + {1'b0, push} - {1'b0, pop};
  end

  assign below_full = (count_next < FULL_COUNT);

  generate
    for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push && (wr_ptr_reg == 1'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        q_instr_reg[i] <= '0;
        q_pc_reg[i]    <= '0;
        q_pc4_reg[i]   <= '0;
      end
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        if (wr_en[i]) begin
          q_instr_reg[i] <= fetch.imem_rdata;
          q_pc_reg[i]    <= addr_reg;
          q_pc4_reg[i]   <= add_sum;
        end
      end
      if (redirect_valid) begin
        rd_ptr_reg <= 1'b0;
        wr_ptr_reg <= 1'b0;
      end else begin
        if (push) wr_ptr_reg <= ~wr_ptr_reg;
        if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_next;
    end
  end

  assign fetch.if_valid    = (count_reg != 2'd0);
  assign fetch.if_instr    = q_instr_reg[rd_ptr_reg];
  assign fetch.if_pc       = q_pc_reg[rd_ptr_reg];
  assign fetch.if_pc_plus4 = q_pc4_reg[rd_ptr_reg];
  assign fetch.imem_req    = req_reg;
  assign fetch.imem_addr   = addr_reg;

  // DROP keeps the orphaned request alive until memory acks it; pc already
  // holds the redirect target and becomes the next fetch address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
      addr_reg  <= RESET_PC;
      req_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (redirect_valid) pc_reg <= target_pc;
          if (below_full) begin
            state_reg <= FETCH;
            req_reg   <= 1'b1;
            addr_reg  <= redirect_valid ? target_pc : pc_reg;
          end
        end
        FETCH: begin
          if (redirect_valid) begin
            pc_reg <= target_pc;
            if (fetch.imem_ack)
              addr_reg <= target_pc;
            else
              state_reg <= DROP;
          end else if (fetch.imem_ack) begin
            pc_reg <= add_sum;
            if (below_full) begin
              addr_reg <= add_sum;
            end else begin
              state_reg <= IDLE;
              req_reg   <= 1'b0;
            end
          end
        end
        DROP: begin
          if (redirect_valid) pc_reg <= target_pc;
          if (fetch.imem_ack) begin
            addr_reg  <= redirect_valid ? target_pc : pc_reg;
            state_reg <= FETCH;
          end
        end
        default: begin
          state_reg <= IDLE;
          req_reg   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Bench for pc_fetch_stage: expected {instr, pc, pc+4} entries are queued per
// scenario and popped by a monitor on every decode handshake.
module tb_pc_fetch_stage;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] add_in1;
  logic [31:0] add_in2;
  logic [31:0] add_sum;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        mem_en;
  int          ack_delay;
  int          wait_cnt;
  int          cyc;
  int          n_cmp;
  int          n_bad;
  int          pop_cnt;
  int          first_pop_cyc;
  int          last_pop_cyc;
  exp_t        exp_q[$];

  pc_fetch_stage_if bus ();

  pc_fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .add_in1        (add_in1),
    .add_in2        (add_in2),
    .add_sum        (add_sum),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch          (bus.master)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign add_sum        = add_in1 + add_in2;
  assign bus.imem_rdata = mem_word(bus.imem_addr);
  always_comb bus.imem_ack = bus.imem_req && mem_en && (wait_cnt >= ack_delay);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst || !bus.imem_req || bus.imem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  // Scoreboard monitor: every accepted head must match the next expected entry.
  always @(negedge clk) begin
    if (!rst && bus.if_valid && bus.if_ready && !redirect_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pop: got pc=%h, required no handshake", bus.if_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({bus.if_instr, bus.if_pc, bus.if_pc_plus4} !== {e.instr, e.pc, e.pc4}) begin
          n_bad++;
          $display("FAIL pop_entry: got instr=%h pc=%h pc4=%h, required instr=%h pc=%h pc4=%h",
                   bus.if_instr, bus.if_pc, bus.if_pc_plus4, e.instr, e.pc, e.pc4);
        end else begin
          $display("pop pc=%h instr=%h pc4=%h ok", bus.if_pc, bus.if_instr, bus.if_pc_plus4);
        end
      end
      pop_cnt++;
      if (pop_cnt == 1) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.instr = mem_word(pc);
    e.pc    = pc;
    e.pc4   = pc + 32'd4;
    exp_q.push_back(e);
  endtask

  task automatic hold_reset();
    rst            = 1'b1;
    bus.if_ready   = 1'b0;
    mem_en         = 1'b1;
    ack_delay      = 0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    tick();
    tick();
    exp_q.delete();
    pop_cnt = 0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    bus.if_ready = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain: got %0d entries left, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    hold_reset();
    n_cmp++;
    if ({bus.imem_req, bus.if_valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_req_valid: got %b, required 00", {bus.imem_req, bus.if_valid});
    end
    n_cmp++;
    if ({bus.imem_addr, bus.if_instr, bus.if_pc, bus.if_pc_plus4} !== 128'h0) begin
      n_bad++;
      $display("FAIL reset_fields: got addr=%h instr=%h pc=%h pc4=%h, required all 0",
               bus.imem_addr, bus.if_instr, bus.if_pc, bus.if_pc_plus4);
    end
    n_cmp++;
    if ({add_in1, add_in2} !== {32'h0, 32'd4}) begin
      n_bad++;
      $display("FAIL reset_adder: got in1=%h in2=%h, required 0 / 4", add_in1, add_in2);
    end
    rst = 1'b0;
    n_cmp++;
    if (bus.imem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL release_req_low: got %b, required 0", bus.imem_req);
    end
    tick();
    n_cmp++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      n_bad++;
      $display("FAIL release_req_rise: got req=%b addr=%h, required 1 / 0", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_stream();
    hold_reset();
    bus.if_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_exp(32'(i * 4));
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({bus.imem_req, bus.imem_ack, bus.if_valid} !== 3'b110) begin
      n_bad++;
      $display("FAIL stream_first_ack: got req/ack/valid=%b, required 110",
               {bus.imem_req, bus.imem_ack, bus.if_valid});
    end
    tick();
    n_cmp++;
    if (bus.if_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL stream_valid_rise: got %b, required 1", bus.if_valid);
    end
    drain("stream");
    n_cmp++;
    if (pop_cnt != 4 || last_pop_cyc - first_pop_cyc != 3) begin
      n_bad++;
      $display("FAIL stream_rate: got %0d pops over %0d cycles, required 4 over 3",
               pop_cnt, last_pop_cyc - first_pop_cyc);
    end
  endtask

  task automatic test_stall();
    hold_reset();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    n_cmp++;
    if ({bus.imem_req, bus.if_valid} !== 2'b01 || bus.if_pc !== 32'h0 || add_in1 !== 32'h8) begin
      n_bad++;
      $display("FAIL stall_full: got req=%b valid=%b pc_head=%h pc=%h, required 0 1 0 8",
               bus.imem_req, bus.if_valid, bus.if_pc, add_in1);
    end
    push_exp(32'h0);
    push_exp(32'h4);
    push_exp(32'h8);
    bus.if_ready = 1'b1;
    drain("stall");
  endtask

  task automatic test_ack_delay();
    hold_reset();
    ack_delay    = 3;
    bus.if_ready = 1'b1;
    push_exp(32'h0);
    push_exp(32'h4);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({bus.imem_req, bus.imem_ack} !== 2'b10 || bus.imem_addr !== 32'h0 || add_in1 !== 32'h0) begin
        n_bad++;
        $display("FAIL delay_wait%0d: got req=%b ack=%b addr=%h pc=%h, required 1 0 0 0",
                 i, bus.imem_req, bus.imem_ack, bus.imem_addr, add_in1);
      end
    end
    tick();
    n_cmp++;
    if (bus.imem_ack !== 1'b1) begin
      n_bad++;
      $display("FAIL delay_ack: got %b, required 1", bus.imem_ack);
    end
    tick();
    n_cmp++;
    if (add_in1 !== 32'h4 || bus.imem_addr !== 32'h4 || bus.if_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL delay_advance: got pc=%h addr=%h valid=%b, required 4 4 1",
               add_in1, bus.imem_addr, bus.if_valid);
    end
    drain("delay");
  endtask

  task automatic test_redirect_pending();
    hold_reset();
    bus.if_ready = 1'b1;
    push_exp(32'h0);
    rst = 1'b0;
    tick();
    tick();
    tick();
    n_cmp++;
    if (bus.imem_addr !== 32'h8 || bus.if_pc !== 32'h4 || bus.if_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL redir_setup: got addr=%h head=%h valid=%b, required 8 4 1",
               bus.imem_addr, bus.if_pc, bus.if_valid);
    end
    bus.if_ready   = 1'b0;
    mem_en         = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    n_cmp++;
    if (bus.if_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8 || add_in1 !== 32'h100) begin
      n_bad++;
      $display("FAIL redir_flush: got valid=%b req=%b addr=%h pc=%h, required 0 1 8 100",
               bus.if_valid, bus.imem_req, bus.imem_addr, add_in1);
    end
    mem_en = 1'b1;
    push_exp(32'h100);
    push_exp(32'h104);
    bus.if_ready = 1'b1;
    tick();
    n_cmp++;
    if (bus.imem_addr !== 32'h100 || bus.imem_req !== 1'b1) begin
      n_bad++;
      $display("FAIL redir_refetch: got addr=%h req=%b, required 100 1", bus.imem_addr, bus.imem_req);
    end
    drain("redir");
  endtask

  task automatic test_wrap();
    hold_reset();
    rst = 1'b0;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    n_cmp++;
    if (bus.imem_addr !== 32'hFFFF_FFFC || add_in1 !== 32'hFFFF_FFFC || bus.if_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_redirect: got addr=%h pc=%h valid=%b, required FFFFFFFC FFFFFFFC 0",
               bus.imem_addr, add_in1, bus.if_valid);
    end
    push_exp(32'hFFFF_FFFC);
    push_exp(32'h0000_0000);
    bus.if_ready = 1'b1;
    drain("wrap");
  endtask

  task automatic test_reset_midfetch();
    hold_reset();
    rst = 1'b0;
    tick();
    tick();
    mem_en = 1'b0;
    n_cmp++;
    if ({bus.imem_req, bus.if_valid} !== 2'b11) begin
      n_bad++;
      $display("FAIL midrst_setup: got req/valid=%b, required 11", {bus.imem_req, bus.if_valid});
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.imem_req, bus.if_valid} !== 2'b00 || bus.imem_addr !== 32'h0 || bus.if_pc !== 32'h0) begin
      n_bad++;
      $display("FAIL midrst_async: got req=%b valid=%b addr=%h pc=%h, required 0 0 0 0",
               bus.imem_req, bus.if_valid, bus.imem_addr, bus.if_pc);
    end
    tick();
    tick();
    mem_en = 1'b1;
    push_exp(32'h0);
    push_exp(32'h4);
    bus.if_ready = 1'b1;
    rst = 1'b0;
    tick();
    n_cmp++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      n_bad++;
      $display("FAIL midrst_restart: got req=%b addr=%h, required 1 0", bus.imem_req, bus.imem_addr);
    end
    drain("midrst");
  endtask

  initial begin
    n_cmp          = 0;
    n_bad          = 0;
    cyc            = 0;
    wait_cnt       = 0;
    pop_cnt        = 0;
    first_pop_cyc  = 0;
    last_pop_cyc   = 0;
    rst            = 1'b1;
    mem_en         = 1'b1;
    ack_delay      = 0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    bus.if_ready   = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_ack_delay();
    test_redirect_pending();
    test_wrap();
    test_reset_midfetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
